// File: rtl/omr_pkg.sv
// Shared definitions for the OMR scanner and grader: sheet geometry,
// scanner FSM states and the packed answer word type.
package omr_pkg;

   localparam int NUM_Q_DEFAULT = 10;
   localparam int OPT_W_DEFAULT = 4;
   localparam int CNT_W         = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } omr_state_e;

   typedef logic [NUM_Q_DEFAULT*OPT_W_DEFAULT-1:0] answer_word_t;

   // Two or more bubbles marked: clearing the lowest set bit leaves something.
   function automatic logic multi_marked(input logic [OPT_W_DEFAULT-1:0] row);
      logic [OPT_W_DEFAULT-1:0] low_cleared;
      low_cleared = row & (row - {{(OPT_W_DEFAULT-1){1'b0}}, 1'b1});
      return (low_cleared != {OPT_W_DEFAULT{1'b0}});
   endfunction

endpackage

// File: rtl/omr_row_check.sv
// Combinational one-hot check of a single bubble row; only a clean
// one-hot row is passed through, anything else is forced to zero.
module omr_row_check
   import omr_pkg::*;
#(
   parameter int OPT_W = OPT_W_DEFAULT
) (
   input  logic [OPT_W-1:0] row_bits,
   output logic [OPT_W-1:0] row_clean,
   output logic             is_blank,
   output logic             is_multi
);

   logic [OPT_W-1:0] low_cleared_s;

   // Classify the row and derive the value that will be packed.
   always_comb begin
      low_cleared_s = row_bits & (row_bits - {{(OPT_W-1){1'b0}}, 1'b1});
      is_blank      = (row_bits == {OPT_W{1'b0}});
      is_multi      = (low_cleared_s != {OPT_W{1'b0}});
      if (is_blank || is_multi) begin
         row_clean = {OPT_W{1'b0}};
      end else begin
         row_clean = row_bits;
      end
   end

endmodule

// File: rtl/omr_sheet_scanner.sv
// Collects one bubble row per question into the packed answer word, flags
// blank/multi-marked questions and offers the sheet over a valid/ready handshake.
module omr_sheet_scanner
   import omr_pkg::*;
#(
   parameter int NUM_Q = NUM_Q_DEFAULT,
   parameter int OPT_W = OPT_W_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   sheet_start,
   input  logic                   row_valid,
   input  logic [OPT_W-1:0]       row_bits,
   output logic                   row_ready,
   output logic [NUM_Q*OPT_W-1:0] student_answers,
   output logic [NUM_Q-1:0]       blank_mask,
   output logic [NUM_Q-1:0]       multi_mask,
   output logic [CNT_W-1:0]       blank_count,
   output logic [CNT_W-1:0]       multi_count,
   output logic                   sheet_valid,
   input  logic                   sheet_ready,
   output logic                   abort
);

   localparam int                W        = NUM_Q * OPT_W;
   localparam int                IDX_W    = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_Q - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(NUM_Q);
   localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   omr_state_e       state_q;
   logic [IDX_W-1:0] index_q;
   logic [W-1:0]     answers_q;
   logic [NUM_Q-1:0] blank_q;
   logic [NUM_Q-1:0] multi_q;
   logic [CNT_W-1:0] blank_cnt_q;
   logic [CNT_W-1:0] multi_cnt_q;
   logic             row_ready_q;
   logic             sheet_valid_q;
   logic             abort_q;

   logic [W-1:0]     answers_d;
   logic [NUM_Q-1:0] blank_d;
   logic [NUM_Q-1:0] multi_d;
   logic [CNT_W-1:0] blank_cnt_d;
   logic [CNT_W-1:0] multi_cnt_d;

   logic [OPT_W-1:0] row_clean_s;
   logic             is_blank_s;
   logic             is_multi_s;

   omr_row_check #(
      .OPT_W (OPT_W)
   ) u_row_check (
      .row_bits  (row_bits),
      .row_clean (row_clean_s),
      .is_blank  (is_blank_s),
      .is_multi  (is_multi_s)
   );

   // Sheet contents as they would look after accepting the current row.
   always_comb begin
      answers_d = answers_q;
      blank_d   = blank_q;
      multi_d   = multi_q;
      for (int i = 0; i < NUM_Q; i++) begin
         if (index_q == IDX_W'(i)) begin
            answers_d[(NUM_Q-1-i)*OPT_W +: OPT_W] = row_clean_s;
            blank_d[NUM_Q-1-i] = blank_q[NUM_Q-1-i] | is_blank_s;
            multi_d[NUM_Q-1-i] = multi_q[NUM_Q-1-i] | is_multi_s;
         end else begin
            answers_d[(NUM_Q-1-i)*OPT_W +: OPT_W] = answers_q[(NUM_Q-1-i)*OPT_W +: OPT_W];
         end
      end
      if (is_blank_s && (blank_cnt_q < CNT_MAX)) begin
         blank_cnt_d = blank_cnt_q + CNT_ONE;
      end else begin
         blank_cnt_d = blank_cnt_q;
      end
      if (is_multi_s && (multi_cnt_q < CNT_MAX)) begin
         multi_cnt_d = multi_cnt_q + CNT_ONE;
      end else begin
         multi_cnt_d = multi_cnt_q;
      end
   end

   // Sheet FSM with all outputs held in registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         index_q       <= {IDX_W{1'b0}};
         answers_q     <= {W{1'b0}};
         blank_q       <= {NUM_Q{1'b0}};
         multi_q       <= {NUM_Q{1'b0}};
         blank_cnt_q   <= {CNT_W{1'b0}};
         multi_cnt_q   <= {CNT_W{1'b0}};
         row_ready_q   <= 1'b0;
         sheet_valid_q <= 1'b0;
         abort_q       <= 1'b0;
      end else begin
         abort_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sheet_start) begin
                  state_q     <= COLLECT;
                  row_ready_q <= 1'b1;
                  index_q     <= {IDX_W{1'b0}};
                  answers_q   <= {W{1'b0}};
                  blank_q     <= {NUM_Q{1'b0}};
                  multi_q     <= {NUM_Q{1'b0}};
                  blank_cnt_q <= {CNT_W{1'b0}};
                  multi_cnt_q <= {CNT_W{1'b0}};
               end
            end
            COLLECT: begin
               // A restart wins over a row arriving in the same cycle.
               if (sheet_start) begin
                  abort_q     <= 1'b1;
                  index_q     <= {IDX_W{1'b0}};
                  answers_q   <= {W{1'b0}};
                  blank_q     <= {NUM_Q{1'b0}};
                  multi_q     <= {NUM_Q{1'b0}};
                  blank_cnt_q <= {CNT_W{1'b0}};
                  multi_cnt_q <= {CNT_W{1'b0}};
               end else if (row_valid) begin
                  answers_q   <= answers_d;
                  blank_q     <= blank_d;
                  multi_q     <= multi_d;
                  blank_cnt_q <= blank_cnt_d;
                  multi_cnt_q <= multi_cnt_d;
                  index_q     <= index_q + IDX_ONE;
                  if (index_q == LAST_IDX) begin
                     state_q       <= HOLD;
                     row_ready_q   <= 1'b0;
                     sheet_valid_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (sheet_ready) begin
                  state_q       <= IDLE;
                  sheet_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q       <= IDLE;
               row_ready_q   <= 1'b0;
               sheet_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign row_ready       = row_ready_q;
   assign student_answers = answers_q;
   assign blank_mask      = blank_q;
   assign multi_mask      = multi_q;
   assign blank_count     = blank_cnt_q;
   assign multi_count     = multi_cnt_q;
   assign sheet_valid     = sheet_valid_q;
   assign abort           = abort_q;

endmodule

// File: tb/tb_omr_sheet_scanner.sv
// Directed bench for omr_sheet_scanner: inputs change and outputs are
// checked on the falling edge, expected values are hand-computed constants.
module tb_omr_sheet_scanner;
   import omr_pkg::*;

   logic         clk;
   logic         reset_n;
   logic         sheet_start;
   logic         row_valid;
   logic [3:0]   row_bits;
   logic         row_ready;
   answer_word_t student_answers;
   logic [9:0]   blank_mask;
   logic [9:0]   multi_mask;
   logic [3:0]   blank_count;
   logic [3:0]   multi_count;
   logic         sheet_valid;
   logic         sheet_ready;
   logic         abort;

   int n_assert = 0;
   int n_fail   = 0;

   omr_sheet_scanner dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .sheet_start     (sheet_start),
      .row_valid       (row_valid),
      .row_bits        (row_bits),
      .row_ready       (row_ready),
      .student_answers (student_answers),
      .blank_mask      (blank_mask),
      .multi_mask      (multi_mask),
      .blank_count     (blank_count),
      .multi_count     (multi_count),
      .sheet_valid     (sheet_valid),
      .sheet_ready     (sheet_ready),
      .abort           (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives questions first..first+n-1 from a packed word (question 0 = MSB nibble).
   task automatic feed(input logic [39:0] word, input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         row_valid = 1'b1;
         row_bits  = word[(9-i)*4 +: 4];
         @(negedge clk);
      end
      row_valid = 1'b0;
      row_bits  = 4'h0;
   endtask

   task automatic start_sheet;
      sheet_start = 1'b1;
      @(negedge clk);
      sheet_start = 1'b0;
   endtask

   task automatic check_sheet(input string tag, input logic [39:0] ans,
                              input logic [9:0] bm, input logic [9:0] mm,
                              input logic [3:0] bc, input logic [3:0] mc);
      check({tag, "_valid"}, {39'd0, sheet_valid}, 40'd1);
      check({tag, "_rdy"},   {39'd0, row_ready},   40'd0);
      check({tag, "_ans"},   student_answers,      ans);
      check({tag, "_bmask"}, {30'd0, blank_mask},  {30'd0, bm});
      check({tag, "_mmask"}, {30'd0, multi_mask},  {30'd0, mm});
      check({tag, "_bcnt"},  {36'd0, blank_count}, {36'd0, bc});
      check({tag, "_mcnt"},  {36'd0, multi_count}, {36'd0, mc});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rdy"},   {39'd0, row_ready},   40'd0);
      check({tag, "_valid"}, {39'd0, sheet_valid}, 40'd0);
      check({tag, "_abort"}, {39'd0, abort},       40'd0);
      check({tag, "_ans"},   student_answers,      40'd0);
      check({tag, "_masks"}, {20'd0, blank_mask, multi_mask}, 40'd0);
      check({tag, "_cnts"},  {32'd0, blank_count, multi_count}, 40'd0);
   endtask

   initial begin
      reset_n     = 1'b0;
      sheet_start = 1'b0;
      row_valid   = 1'b0;
      row_bits    = 4'h0;
      sheet_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_rdy", {39'd0, row_ready}, 40'd0);

      // Clean sheet, latency of sheet_valid
      start_sheet();
      check("collect_rdy", {39'd0, row_ready}, 40'd1);
      feed(40'h1224121888, 0, 9);
      check("clean_early_valid", {39'd0, sheet_valid}, 40'd0);
      check("clean_partial", student_answers, 40'h1224121880);
      feed(40'h1224121888, 9, 1);
      check_sheet("clean", 40'h1224121888, 10'b0, 10'b0, 4'd0, 4'd0);

      // Backpressure in HOLD with ignored rows and an ignored start
      for (int i = 0; i < 5; i++) begin
         row_valid   = 1'b1;
         row_bits    = 4'h3;
         sheet_start = (i == 2);
         @(negedge clk);
         check_sheet("hold", 40'h1224121888, 10'b0, 10'b0, 4'd0, 4'd0);
      end
      row_valid   = 1'b0;
      sheet_start = 1'b0;
      sheet_ready = 1'b1;
      @(negedge clk);
      sheet_ready = 1'b0;
      check("xfer_valid", {39'd0, sheet_valid}, 40'd0);
      check("xfer_rdy",   {39'd0, row_ready},   40'd0);

      // Start and row together in IDLE: no row taken
      sheet_start = 1'b1;
      row_valid   = 1'b1;
      row_bits    = 4'h8;
      @(negedge clk);
      sheet_start = 1'b0;
      row_valid   = 1'b0;
      check("idle_row_drop", student_answers, 40'd0);
      check("idle_row_rdy", {39'd0, row_ready}, 40'd1);
      feed(40'h8421524212, 0, 10);
      check_sheet("mixed", 40'h8421024212, 10'b0, 10'b0000100000, 4'd0, 4'd1);
      sheet_ready = 1'b1;
      @(negedge clk);
      sheet_ready = 1'b0;

      // Blank at last question
      start_sheet();
      feed(40'h1111111110, 0, 10);
      check_sheet("blank9", 40'h1111111110, 10'b0000000001, 10'b0, 4'd1, 4'd0);
      sheet_ready = 1'b1;
      @(negedge clk);
      sheet_ready = 1'b0;

      // Several blanks/multis, ready held high before valid
      start_sheet();
      sheet_ready = 1'b1;
      feed(40'h0F03124806, 0, 10);
      check_sheet("many", 40'h0000124800, 10'b1010000010, 10'b0101000001, 4'd3, 4'd3);
      @(negedge clk);
      sheet_ready = 1'b0;
      check("early_ready_xfer", {39'd0, sheet_valid}, 40'd0);

      // Abort after 4 rows, with a row in the restart cycle
      start_sheet();
      feed(40'h0051000000, 0, 4);
      check("pre_abort_bcnt", {36'd0, blank_count}, 40'd2);
      check("pre_abort_mcnt", {36'd0, multi_count}, 40'd1);
      check("pre_abort_ans", student_answers, 40'h0001000000);
      sheet_start = 1'b1;
      row_valid   = 1'b1;
      row_bits    = 4'h2;
      @(negedge clk);
      sheet_start = 1'b0;
      row_valid   = 1'b0;
      check("abort_pulse", {39'd0, abort}, 40'd1);
      check("abort_ans",   student_answers, 40'd0);
      check("abort_masks", {20'd0, blank_mask, multi_mask}, 40'd0);
      check("abort_cnts",  {32'd0, blank_count, multi_count}, 40'd0);
      check("abort_rdy",   {39'd0, row_ready}, 40'd1);
      feed(40'h1111111111, 0, 1);
      check("abort_once", {39'd0, abort}, 40'd0);
      feed(40'h1111111111, 1, 9);
      check_sheet("after_abort", 40'h1111111111, 10'b0, 10'b0, 4'd0, 4'd0);
      sheet_ready = 1'b1;
      @(negedge clk);
      sheet_ready = 1'b0;

      // Asynchronous reset mid-sheet
      start_sheet();
      feed(40'h2222220000, 0, 6);
      check("pre_reset_ans", student_answers, 40'h2222220000);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");
      start_sheet();
      feed(40'h4444444444, 0, 10);
      check_sheet("recover", 40'h4444444444, 10'b0, 10'b0, 4'd0, 4'd0);
      check("recover_abort", {39'd0, abort}, 40'd0);
      sheet_ready = 1'b1;
      @(negedge clk);
      sheet_ready = 1'b0;
      check("recover_xfer", {39'd0, sheet_valid}, 40'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
